// File: rtl/hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_ctrl: forwarding selects, stall/flush controls and data-memory    |
// | wait-state FSM with timeout. Optional counters: HAZARD_PERF_EN.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hazard_ctrl #(
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  i_RA1D,
    input  logic [3:0]  i_RA2D,
    input  logic [3:0]  i_RA1E,
    input  logic [3:0]  i_RA2E,
    input  logic [3:0]  i_WA3E,
    input  logic [3:0]  i_WA3M,
    input  logic [3:0]  i_WA3W,
    input  logic        i_RegWriteM,
    input  logic        i_RegWriteW,
    input  logic        i_MemtoRegE,
    input  logic        i_PCSrcD,
    input  logic        i_PCSrcE,
    input  logic        i_PCSrcM,
    input  logic        i_BranchTakenE,
    input  logic        i_MemReqM,
    input  logic        i_MemReadyM,
    output logic [1:0]  o_ForwardAE,
    output logic [1:0]  o_ForwardBE,
    output logic        o_StallF,
    output logic        o_StallD,
    output logic        o_StallE,
    output logic        o_StallM,
    output logic        o_FlushD,
    output logic        o_FlushE,
    output logic        o_FlushW,
    output logic        o_MemTimeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] o_StallCnt,
    output logic [31:0] o_FlushCnt,
    output logic [31:0] o_WaitCnt
`endif
);

    localparam logic [1:0] FORWARD_FROM_ID  = 2'b00;
    localparam logic [1:0] FORWARD_FROM_WB  = 2'b01;
    localparam logic [1:0] FORWARD_FROM_MEM = 2'b10;
    localparam logic [7:0] C_WAIT_TIMEOUT   = 8'(WAIT_TIMEOUT);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MWAIT = 2'd1,
        ERR   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;

    logic       w_ldstall;
    logic       w_pcpend;
    logic       w_memwait;
    logic       w_freeze;

    // Register 15 is the PC and is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [3:0] ra, input logic [3:0] wa_m, input logic we_m,
        input logic [3:0] wa_w, input logic we_w
    );
        if (we_m && wa_m == ra && ra != 4'd15)      return FORWARD_FROM_MEM;
        else if (we_w && wa_w == ra && ra != 4'd15) return FORWARD_FROM_WB;
        else                                        return FORWARD_FROM_ID;
    endfunction

    assign w_ldstall = i_MemtoRegE && (i_WA3E == i_RA1D || i_WA3E == i_RA2D);
    assign w_pcpend  = i_PCSrcD | i_PCSrcE | i_PCSrcM;
    assign w_memwait = i_MemReqM & ~i_MemReadyM;
    assign w_freeze  = w_memwait | (state_q == ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (w_memwait) state_d = MWAIT;
            MWAIT: begin
                if (i_MemReadyM)                      state_d = RUN;
                else if (wait_cnt_q >= C_WAIT_TIMEOUT) state_d = ERR;
            end
            ERR:     state_d = ERR;
            default: state_d = RUN;
        endcase

        wait_cnt_d = wait_cnt_q;
        if (i_MemReadyM || (state_q == MWAIT && state_d != MWAIT))
            wait_cnt_d = 8'd0;
        else if (w_freeze && state_q != ERR && wait_cnt_q != 8'hFF)
            wait_cnt_d = wait_cnt_q + 8'd1;

        timeout_d = timeout_q | (state_d == ERR);

        o_ForwardAE = fwd_sel(i_RA1E, i_WA3M, i_RegWriteM, i_WA3W, i_RegWriteW);
        o_ForwardBE = fwd_sel(i_RA2E, i_WA3M, i_RegWriteM, i_WA3W, i_RegWriteW);
        o_StallF    = w_ldstall | w_pcpend;
        o_StallD    = w_ldstall;
        o_StallE    = 1'b0;
        o_StallM    = 1'b0;
        o_FlushD    = w_pcpend | i_BranchTakenE;
        o_FlushE    = w_ldstall | i_BranchTakenE;
        o_FlushW    = 1'b0;

        // Hazards seen while frozen stay in their stage and resolve after the freeze.
        if (w_freeze) begin
            o_StallF = 1'b1;
            o_StallD = 1'b1;
            o_StallE = 1'b1;
            o_StallM = 1'b1;
            o_FlushD = 1'b0;
            o_FlushE = 1'b0;
            o_FlushW = 1'b1;
        end

        if (!rst_n) begin
            o_ForwardAE = FORWARD_FROM_ID;
            o_ForwardBE = FORWARD_FROM_ID;
            o_StallF    = 1'b0;
            o_StallD    = 1'b0;
            o_StallE    = 1'b0;
            o_StallM    = 1'b0;
            o_FlushD    = 1'b1;
            o_FlushE    = 1'b1;
            o_FlushW    = 1'b1;
        end
    end

    assign o_MemTimeout = timeout_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q, wait_cnt_perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q     <= 32'd0;
            flush_cnt_q     <= 32'd0;
            wait_cnt_perf_q <= 32'd0;
        end else begin
            stall_cnt_q     <= stall_cnt_q + {31'd0, o_StallF};
            flush_cnt_q     <= flush_cnt_q + {31'd0, o_FlushE};
            wait_cnt_perf_q <= wait_cnt_perf_q + {31'd0, w_freeze};
        end
    end

    assign o_StallCnt = stall_cnt_q;
    assign o_FlushCnt = flush_cnt_q;
    assign o_WaitCnt  = wait_cnt_perf_q;
`else
    // Counters absent in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hazard_ctrl: scoreboard bench for hazard_ctrl (WAIT_TIMEOUT = 8).      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_hazard_ctrl;

    localparam int unsigned TO   = 8;
    localparam logic [1:0]  F_ID = 2'b00;
    localparam logic [1:0]  F_WB = 2'b01;
    localparam logic [1:0]  F_MEM = 2'b10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] i_RA1D = '0, i_RA2D = '0, i_RA1E = '0, i_RA2E = '0;
    logic [3:0] i_WA3E = '0, i_WA3M = '0, i_WA3W = '0;
    logic i_RegWriteM = 0, i_RegWriteW = 0, i_MemtoRegE = 0;
    logic i_PCSrcD = 0, i_PCSrcE = 0, i_PCSrcM = 0, i_BranchTakenE = 0;
    logic i_MemReqM = 0, i_MemReadyM = 0;
    logic [1:0] o_ForwardAE, o_ForwardBE;
    logic o_StallF, o_StallD, o_StallE, o_StallM, o_FlushD, o_FlushE, o_FlushW, o_MemTimeout;
`ifdef HAZARD_PERF_EN
    logic [31:0] o_StallCnt, o_FlushCnt, o_WaitCnt;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.WAIT_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_RA1D(i_RA1D), .i_RA2D(i_RA2D), .i_RA1E(i_RA1E), .i_RA2E(i_RA2E),
        .i_WA3E(i_WA3E), .i_WA3M(i_WA3M), .i_WA3W(i_WA3W),
        .i_RegWriteM(i_RegWriteM), .i_RegWriteW(i_RegWriteW), .i_MemtoRegE(i_MemtoRegE),
        .i_PCSrcD(i_PCSrcD), .i_PCSrcE(i_PCSrcE), .i_PCSrcM(i_PCSrcM),
        .i_BranchTakenE(i_BranchTakenE), .i_MemReqM(i_MemReqM), .i_MemReadyM(i_MemReadyM),
        .o_ForwardAE(o_ForwardAE), .o_ForwardBE(o_ForwardBE),
        .o_StallF(o_StallF), .o_StallD(o_StallD), .o_StallE(o_StallE), .o_StallM(o_StallM),
        .o_FlushD(o_FlushD), .o_FlushE(o_FlushE), .o_FlushW(o_FlushW),
        .o_MemTimeout(o_MemTimeout)
`ifdef HAZARD_PERF_EN
        , .o_StallCnt(o_StallCnt), .o_FlushCnt(o_FlushCnt), .o_WaitCnt(o_WaitCnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: error flag, in-wait flag, consecutive not-ready count.
    bit m_err = 0, m_wait = 0;
    int m_nr = 0;
    int unsigned m_sc = 0, m_fc = 0, m_wc = 0;

    logic [11:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [1:0] fwd(input logic [3:0] ra);
        if (ra == 4'd15)                     return F_ID;
        if (i_RegWriteM && i_WA3M == ra)     return F_MEM;
        if (i_RegWriteW && i_WA3W == ra)     return F_WB;
        return F_ID;
    endfunction

    task automatic idle();
        {i_RA1D, i_RA2D, i_RA1E, i_RA2E, i_WA3E, i_WA3M, i_WA3W} = '0;
        {i_RegWriteM, i_RegWriteW, i_MemtoRegE, i_PCSrcD, i_PCSrcE, i_PCSrcM} = '0;
        {i_BranchTakenE, i_MemReqM, i_MemReadyM} = '0;
    endtask

    // One cycle: predict, push, compare at negedge, advance model at posedge.
    task automatic step();
        logic ld, pc, fz;
        logic [1:0] fa, fb;
        logic [3:0] st;
        logic [2:0] fl;
        logic [11:0] e, got;
        if (!rst_n) begin
            m_err = 0; m_wait = 0; m_nr = 0; m_sc = 0; m_fc = 0; m_wc = 0;
        end
        ld = i_MemtoRegE && (i_WA3E == i_RA1D || i_WA3E == i_RA2D);
        pc = i_PCSrcD || i_PCSrcE || i_PCSrcM;
        fz = (i_MemReqM && !i_MemReadyM) || m_err;
        fa = fwd(i_RA1E);
        fb = fwd(i_RA2E);
        if (!rst_n) begin
            fa = F_ID; fb = F_ID; st = 4'b0000; fl = 3'b111;
        end else if (fz) begin
            st = 4'b1111; fl = 3'b001;
        end else begin
            st = {ld | pc, ld, 2'b00};
            fl = {pc | i_BranchTakenE, ld | i_BranchTakenE, 1'b0};
        end
        exp_q.push_back({fa, fb, st, fl, m_err});

        @(negedge clk);
        e   = exp_q.pop_front();
        got = {o_ForwardAE, o_ForwardBE, o_StallF, o_StallD, o_StallE, o_StallM,
               o_FlushD, o_FlushE, o_FlushW, o_MemTimeout};
        check("fwdA",    {30'd0, got[11:10]}, {30'd0, e[11:10]});
        check("fwdB",    {30'd0, got[9:8]},   {30'd0, e[9:8]});
        check("stalls",  {28'd0, got[7:4]},   {28'd0, e[7:4]});
        check("flushes", {29'd0, got[3:1]},   {29'd0, e[3:1]});
        check("timeout", {31'd0, got[0]},     {31'd0, e[0]});

        @(posedge clk);
        if (rst_n) begin
            m_sc += st[3]; m_fc += fl[1]; m_wc += fz;
            if (!m_err && (m_wait || (i_MemReqM && !i_MemReadyM))) begin
                if (i_MemReadyM) begin
                    m_wait = 0; m_nr = 0;
                end else begin
                    m_nr++;
                    if (m_nr > TO) m_err = 1;
                    else           m_wait = 1;
                end
            end
        end
        #1;
    endtask

    function automatic logic [3:0] rreg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 4'd15 : 4'(r);
    endfunction

    initial begin
        idle();
        rst_n = 0;
        repeat (2) step();
        rst_n = 1;
        step();

        // Forwarding directed cases
        i_RA1E = 3; i_WA3M = 3; i_RegWriteM = 1; i_WA3W = 3; i_RegWriteW = 1;
        step();
        check("fwd_mem_pri", {30'd0, o_ForwardAE}, {30'd0, F_MEM});
        i_RegWriteM = 0; step();
        i_RA1E = 15; i_RA2E = 3; step();
        idle();

        // Random hazard mix without memory waits
        for (int n = 0; n < 30; n++) begin
            i_RA1D = rreg(); i_RA2D = rreg(); i_RA1E = rreg(); i_RA2E = rreg();
            i_WA3E = rreg(); i_WA3M = rreg(); i_WA3W = rreg();
            i_RegWriteM = 1'($urandom); i_RegWriteW = 1'($urandom);
            i_MemtoRegE = 1'($urandom);
            i_PCSrcD = ($urandom_range(0, 5) == 0); i_PCSrcE = ($urandom_range(0, 5) == 0);
            i_PCSrcM = ($urandom_range(0, 5) == 0); i_BranchTakenE = ($urandom_range(0, 3) == 0);
            i_MemReadyM = 1'($urandom);
            step();
        end
        idle();

        // Load-use then bubble
        i_MemtoRegE = 1; i_WA3E = 5; i_RA2D = 5; step();
        idle(); step();

        // Branch taken, then PC write walking D->E->M
        i_BranchTakenE = 1; step(); idle();
        i_PCSrcD = 1; step(); idle();
        i_PCSrcE = 1; step(); idle();
        i_PCSrcM = 1; step(); idle();
        step();

        // Memory wait with a pending branch, then ready
        i_MemReqM = 1; i_MemReadyM = 0; i_BranchTakenE = 1;
        repeat (4) step();
        i_MemReadyM = 1; step();
        check("flushE_after_wait", {31'd0, o_FlushE}, 32'd1);
        idle(); step();

        // Ready same cycle as request: no freeze
        i_MemReqM = 1; i_MemReadyM = 1; step();
        idle(); step();

        // Timeout
        i_MemReqM = 1; i_MemReadyM = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("timeout_edge", {31'd0, o_MemTimeout}, (k >= TO + 1) ? 32'd1 : 32'd0);
        end
        i_MemReadyM = 1;
        repeat (2) step();
        check("err_freeze", {31'd0, o_StallM}, 32'd1);
        rst_n = 0; step();
        check("timeout_rst", {31'd0, o_MemTimeout}, 32'd0);
        rst_n = 1; idle(); step();
        check("run_after_rst", {31'd0, o_StallM}, 32'd0);

`ifdef HAZARD_PERF_EN
        rst_n = 0; step();
        rst_n = 1; idle(); step();
        for (int n = 0; n < 3; n++) begin
            i_MemtoRegE = 1; i_WA3E = 5; i_RA2D = 5; step();
            idle(); step();
        end
        for (int n = 0; n < 2; n++) begin
            i_MemReqM = 1; i_MemReadyM = 0; step();
            i_MemReadyM = 1; step();
            idle(); step();
        end
        check("stall_cnt", o_StallCnt, 32'd5);
        check("flush_cnt", o_FlushCnt, 32'd3);
        check("wait_cnt",  o_WaitCnt,  32'd2);
        check("stall_cnt_model", o_StallCnt, m_sc);
        check("wait_cnt_model",  o_WaitCnt,  m_wc);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
